// File: rtl/switch_input_ctrl.sv
`timescale 1ns/1ps
// switch_input_ctrl
// Bus-mapped DIP-switch reader. Each of CHANNELS banks (CH_WIDTH bits) is
// synchronised, debounced and tracked for per-bit changes. Software reads the
// debounced value and change flags through a 4-word register window, and a
// maskable level interrupt reports unacknowledged changes.
// CHANNELS*CH_WIDTH must not exceed 32; DEBOUNCE_CYCLES and SYNC_STAGES >= 2.
//
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   dipsw  raw asynchronous switch inputs, bank i = [i*CH_WIDTH +: CH_WIDTH]
//   addr   word select: 0=DATA, 1=CHANGED (W1C), 2=MASK, 3=CTRL
//   we     write strobe for the register at addr
//   din    write data
//   dout   registered read data for addr (valid one cycle after addr)
//   irq    registered level interrupt: CTRL[0] & |(CHANGED & MASK)
module switch_input_ctrl #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned CH_WIDTH        = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*CH_WIDTH-1:0] dipsw,
    input  logic [1:0]                   addr,
    input  logic                         we,
    input  logic [31:0]                  din,
    output logic [31:0]                  dout,
    output logic                         irq
);

    localparam int unsigned W     = CHANNELS * CH_WIDTH;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] A_DATA    = 2'd0;
    localparam logic [1:0] A_CHANGED = 2'd1;
    localparam logic [1:0] A_MASK    = 2'd2;
    localparam logic [1:0] A_CTRL    = 2'd3;

    logic [W-1:0]     sync_q [SYNC_STAGES];
    logic [W-1:0]     sync_val;

    logic [W-1:0]     cand_q,    cand_d;
    logic [W-1:0]     stable_q,  stable_d;
    logic [CNT_W-1:0] cnt_q [CHANNELS];
    logic [CNT_W-1:0] cnt_d [CHANNELS];
    logic [W-1:0]     changed_q, changed_d;
    logic [W-1:0]     mask_q,    mask_d;
    logic [1:0]       ctrl_q,    ctrl_d;
    logic [W-1:0]     clr_bits;
    logic [31:0]      rdata;
    logic             irq_d;

    // Synchroniser chain; deliberately not reset so that debouncing resumes
    // from the live pin state as soon as rst_n is released.
    always_ff @(posedge clk) begin
        sync_q[0] <= dipsw;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
    end

    assign sync_val = sync_q[SYNC_STAGES-1];

    // Per-bank debounce: candidate tracks the synchronised value, the counter
    // measures how long it has been steady while differing from stable.
    // Bypass lets stable follow the candidate's incoming value directly.
    always_comb begin
        cand_d   = sync_val;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (ctrl_q[1]) begin
                stable_d[i*CH_WIDTH +: CH_WIDTH] = sync_val[i*CH_WIDTH +: CH_WIDTH];
                cnt_d[i] = '0;
            end else if (sync_val[i*CH_WIDTH +: CH_WIDTH] != cand_q[i*CH_WIDTH +: CH_WIDTH]) begin
                cnt_d[i] = '0;
            end else if (cand_q[i*CH_WIDTH +: CH_WIDTH] != stable_q[i*CH_WIDTH +: CH_WIDTH]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i*CH_WIDTH +: CH_WIDTH] = cand_q[i*CH_WIDTH +: CH_WIDTH];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    // Register-window writes; a new change event beats a same-cycle clear.
    always_comb begin
        clr_bits = '0;
        mask_d   = mask_q;
        ctrl_d   = ctrl_q;
        if (we) begin
            case (addr)
                A_CHANGED: clr_bits = din[W-1:0];
                A_MASK:    mask_d   = din[W-1:0];
                A_CTRL:    ctrl_d   = din[1:0];
                default:   ;
            endcase
        end
        changed_d = (changed_q & ~clr_bits) | (stable_q ^ stable_d);
        irq_d     = ctrl_q[0] & (|(changed_q & mask_q));
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rdata = '0;
        case (addr)
            A_DATA:    rdata = 32'(stable_q);
            A_CHANGED: rdata = 32'(changed_q);
            A_MASK:    rdata = 32'(mask_q);
            A_CTRL:    rdata = 32'(ctrl_q);
            default:   rdata = '0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cand_q    <= '0;
            stable_q  <= '0;
            cnt_q     <= '{default: '0};
            changed_q <= '0;
            mask_q    <= '0;
            ctrl_q    <= '0;
            dout      <= '0;
            irq       <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            changed_q <= changed_d;
            mask_q    <= mask_d;
            ctrl_q    <= ctrl_d;
            dout      <= rdata;
            irq       <= irq_d;
        end
    end

endmodule

// File: tb/tb_switch_input_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for switch_input_ctrl (default parameters).
module tb_switch_input_ctrl;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 8;
    localparam int unsigned DB = 16;
    localparam int unsigned SS = 2;
    localparam int unsigned W  = CH * CW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [W-1:0] dipsw;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    switch_input_ctrl #(
        .CHANNELS(CH), .CH_WIDTH(CW), .DEBOUNCE_CYCLES(DB), .SYNC_STAGES(SS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dipsw(dipsw), .addr(addr),
        .we(we), .din(din), .dout(dout), .irq(irq)
    );

    // Reference model: pin history delayed through a queue, per-bank
    // "steady age" counts, and the software-visible registers.
    logic [W-1:0] m_hist[$];
    logic [W-1:0] m_cand, m_stab, m_chg, m_msk;
    logic [1:0]   m_ctl;
    logic [31:0]  m_dout;
    logic         m_irq;
    int           m_age[CH];

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_stab;
            2'd1:    return m_chg;
            2'd2:    return m_msk;
            default: return {30'd0, m_ctl};
        endcase
    endfunction

    task automatic m_step();
        logic [W-1:0] sync, nstab, clr;
        logic [7:0]   s, c, t;
        int           nage[CH];
        sync = m_hist[0];
        if (!rst_n) begin
            m_cand = '0; m_stab = '0; m_chg = '0; m_msk = '0; m_ctl = '0;
            m_dout = '0; m_irq = 1'b0;
            for (int b = 0; b < CH; b++) m_age[b] = 0;
        end else begin
            nstab = m_stab;
            for (int b = 0; b < CH; b++) begin
                s = 8'(sync >> (b * CW));
                c = 8'(m_cand >> (b * CW));
                t = 8'(m_stab >> (b * CW));
                nage[b] = 0;
                if (m_ctl[1]) begin
                    t = s;
                end else if (s == c && c != t) begin
                    if (m_age[b] == DB - 1) t = c;
                    else nage[b] = m_age[b] + 1;
                end
                nstab = (nstab & ~(W'(8'hFF) << (b * CW))) | (W'(t) << (b * CW));
            end
            clr    = (we && addr == 2'd1) ? din : '0;
            m_dout = m_read(addr);
            m_irq  = m_ctl[0] && ((m_chg & m_msk) != '0);
            m_chg  = (m_chg & ~clr) | (m_stab ^ nstab);
            if (we && addr == 2'd2) m_msk = din;
            if (we && addr == 2'd3) m_ctl = din[1:0];
            m_cand = sync;
            m_stab = nstab;
            m_age  = nage;
        end
        m_hist.push_back(dipsw);
        void'(m_hist.pop_front());
    endtask

    // One clock: advance the model on the edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; we = 1'b0; addr = 2'd0; din = '0;
        repeat (4) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        dipsw = '0;
        do_reset();
        n_vec++;
        if (dout !== 32'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL reset_out dout=%h irq=%b want 0/0", dout, irq);
        end
        dipsw = 32'h1234_5678;
        for (int e = 1; e <= 22; e++) begin
            step();
            exp = (e >= 20) ? 32'h1234_5678 : 32'h0;
            n_vec++;
            if (dout !== exp || dout !== m_dout) begin
                n_err++; $display("FAIL accept_latency edge=%0d got=%h want=%h model=%h", e, dout, exp, m_dout);
            end
        end
        addr = 2'd1;
        step(); step();
        n_vec++;
        if (dout !== 32'h1234_5678 || irq !== 1'b0) begin
            n_err++; $display("FAIL changed_after_reset got=%h irq=%b want 12345678/0", dout, irq);
        end
    endtask

    task automatic test_bounce();
        logic [7:0] exp;
        addr = 2'd0;
        for (int k = 0; k < 60; k++) begin
            dipsw[7:0] = (k >= 35 || ((k / 5) % 2) == 1) ? 8'hFF : 8'h00;
            step();
            exp = (k - 34 >= 20) ? 8'hFF : 8'h78;
            n_vec++;
            if (dout[7:0] !== exp || dout !== m_dout) begin
                n_err++; $display("FAIL bounce k=%0d got=%h want=%h model=%h", k, dout, exp, m_dout);
            end
        end
    endtask

    task automatic test_irq();
        dipsw = '0;
        do_reset();
        we = 1'b1; addr = 2'd2; din = 32'h0000_00FF; step();
        addr = 2'd3; din = 32'h1; step();
        we = 1'b0; addr = 2'd1;
        repeat (3) step();
        dipsw = 32'h1;
        for (int e = 1; e <= 25; e++) begin
            step();
            n_vec++;
            if (irq !== (e >= 20) || irq !== m_irq || dout !== m_dout) begin
                n_err++; $display("FAIL irq_rise edge=%0d irq=%b model_irq=%b dout=%h model=%h", e, irq, m_irq, dout, m_dout);
            end
            if (e == 20) begin
                n_vec++;
                if (dout !== 32'h1) begin
                    n_err++; $display("FAIL changed_bit0 got=%h want=00000001", dout);
                end
            end
        end
        we = 1'b1; din = 32'h1; step();
        n_vec++;
        if (irq !== 1'b1) begin
            n_err++; $display("FAIL irq_clear_edge irq=%b want 1", irq);
        end
        we = 1'b0; step();
        n_vec++;
        if (irq !== 1'b0) begin
            n_err++; $display("FAIL irq_cleared irq=%b want 0", irq);
        end
        dipsw = 32'h101;
        for (int e = 1; e <= 25; e++) begin
            step();
            n_vec++;
            if (irq !== 1'b0) begin
                n_err++; $display("FAIL irq_masked edge=%0d irq=%b want 0", e, irq);
            end
        end
        n_vec++;
        if (dout !== 32'h100) begin
            n_err++; $display("FAIL changed_bit8 got=%h want=00000100", dout);
        end
    endtask

    task automatic test_set_clear_collision();
        dipsw = 32'h100;
        addr  = 2'd1;
        din   = 32'h1;
        for (int e = 1; e <= 21; e++) begin
            we = (e == 19);
            step();
            if (e == 20) begin
                n_vec++;
                if (dout !== 32'h101 || dout !== m_dout) begin
                    n_err++; $display("FAIL set_beats_clear got=%h want=00000101 model=%h", dout, m_dout);
                end
            end
        end
        we = 1'b0;
    endtask

    task automatic test_bypass();
        logic [31:0] exp;
        dipsw = '0;
        do_reset();
        we = 1'b1; addr = 2'd3; din = 32'hFFFF_FFFE; step();
        we = 1'b0; step(); step();
        n_vec++;
        if (dout !== 32'h2) begin
            n_err++; $display("FAIL ctrl_unimpl got=%h want=00000002", dout);
        end
        addr = 2'd0; step(); step();
        dipsw = 32'hA5;
        for (int e = 1; e <= 5; e++) begin
            step();
            exp = (e >= 4) ? 32'hA5 : 32'h0;
            n_vec++;
            if (dout !== exp || dout !== m_dout) begin
                n_err++; $display("FAIL bypass_latency edge=%0d got=%h want=%h", e, dout, exp);
            end
        end
        we = 1'b1; din = 32'hFFFF_FFFF; step();
        we = 1'b0; step(); step();
        n_vec++;
        if (dout !== 32'hA5) begin
            n_err++; $display("FAIL data_readonly got=%h want=000000a5", dout);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        int          guard;
        dipsw = '0;
        do_reset();
        we = 1'b1; addr = 2'd2; din = 32'hFFFF_FFFF; step();
        we = 1'b0; step(); step();
        dipsw = 32'h3C;
        guard = 0;
        do begin
            step();
            guard++;
        end while (m_age[0] != 10 && guard < 40);
        n_vec++;
        if (guard >= 40 || dout !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL reach_cnt10 guard=%0d dout=%h want ffffffff", guard, dout);
        end
        rst_n = 1'b0; step();
        n_vec++;
        if (dout !== 32'h0 || irq !== 1'b0) begin
            n_err++; $display("FAIL mid_reset dout=%h irq=%b want 0/0", dout, irq);
        end
        rst_n = 1'b1; addr = 2'd0;
        for (int e = 1; e <= 19; e++) begin
            step();
            exp = (e >= 18) ? 32'h3C : 32'h0;
            n_vec++;
            if (dout !== exp || dout !== m_dout) begin
                n_err++; $display("FAIL restart_latency edge=%0d got=%h want=%h", e, dout, exp);
            end
        end
        addr = 2'd2; step(); step();
        n_vec++;
        if (dout !== 32'h0) begin
            n_err++; $display("FAIL mask_after_reset got=%h want 0", dout);
        end
    endtask

    task automatic test_random();
        int b;
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                b = $urandom_range(0, CH - 1);
                dipsw[b*CW +: CW] = 8'($urandom);
            end else if ($urandom_range(0, 59) == 0) begin
                dipsw[$urandom_range(0, W - 1)] ^= 1'b1;
            end
            addr = 2'($urandom);
            we   = ($urandom_range(0, 9) == 0);
            din  = $urandom;
            if (we && addr == 2'd3 && $urandom_range(0, 3) != 0) din[1] = 1'b0;
            step();
            n_vec++;
            if (dout !== m_dout || irq !== m_irq) begin
                n_err++; $display("FAIL random cyc=%0d dout=%h model=%h irq=%b model_irq=%b", i, dout, m_dout, irq, m_irq);
            end
        end
        we = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; dipsw = '0; addr = 2'd0; we = 1'b0; din = '0;
        m_cand = '0; m_stab = '0; m_chg = '0; m_msk = '0; m_ctl = '0;
        m_dout = '0; m_irq = 1'b0;
        for (int b = 0; b < CH; b++) m_age[b] = 0;
        for (int i = 0; i < SS; i++) m_hist.push_back('0);

        test_reset();
        test_bounce();
        test_irq();
        test_set_clear_collision();
        test_bypass();
        test_reset_mid();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout vectors=%0d", n_vec);
        $fatal(1, "timeout");
    end

endmodule
